count_extender: RTL

//  Downstream stage of the 4-bit ripple counter: samples its asynchronously settling

---
 rtl/count_extender.sv | 127 ++++++++++++
 1 files changed

// File: rtl/count_extender.sv
// Extends an asynchronous 4-bit ripple count into a clean {hi,lo} value: the low nibble
// is synchronized and glitch-filtered, and the upper counter advances on each F->0 wrap.
module count_extender #(
   parameter int unsigned HI_WIDTH    = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr,
   input  logic [3:0]            lo_count,
   input  logic                  rco,
   output logic [HI_WIDTH+3:0]   value,
   output logic                  value_valid,
   output logic                  wrap_pulse,
   output logic                  overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [SYNC_STAGES-1:0][3:0]     r_lo_sync;
   logic [SYNC_STAGES-1:0]          r_rco_sync;
   logic [3:0]                      r_s_prev;
   logic [3:0]                      r_lo_q;
   logic [HI_WIDTH-1:0]             r_hi_q;
   logic                            r_rco_seen;
   logic                            r_wrap_pulse;
   logic                            r_overflow;

   logic [3:0]                      w_s_cur;
   logic                            w_rco_s;
   logic                            w_stable;
   logic                            w_seed;
   logic                            w_upd;
   logic                            w_wrap;
   logic                            w_lo_load;

   assign w_s_cur   = r_lo_sync[SYNC_STAGES-1];
   assign w_rco_s   = r_rco_sync[SYNC_STAGES-1];
   assign w_stable  = (w_s_cur == r_s_prev);
   assign w_lo_load = w_seed | w_upd;

   // First flop samples the raw inputs directly; nothing combinational ahead of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lo_sync  <= '0;
         r_rco_sync <= '0;
         r_s_prev   <= '0;
      end else begin
         r_lo_sync  <= {r_lo_sync[SYNC_STAGES-2:0], lo_count};
         r_rco_sync <= {r_rco_sync[SYNC_STAGES-2:0], rco};
         r_s_prev   <= w_s_cur;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_seed      = 1'b0;
      w_upd       = 1'b0;
      w_wrap      = 1'b0;
      case (r_state)
         IDLE: begin
            if (en) w_state_nxt = ARM;
         end
         ARM: begin
            if (!en) begin
               w_state_nxt = IDLE;
            end else if (w_stable) begin
               w_seed      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            // An update sampled on the edge en falls still completes before IDLE.
            if (w_stable && (w_s_cur != r_lo_q)) begin
               w_upd  = 1'b1;
               w_wrap = (w_s_cur < r_lo_q) && (r_rco_seen || w_rco_s);
            end
            if (!en) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (clr) begin
         w_state_nxt = en ? ARM : IDLE;
         w_seed      = 1'b0;
         w_upd       = 1'b0;
         w_wrap      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_lo_q       <= '0;
         r_hi_q       <= '0;
         r_rco_seen   <= 1'b0;
         r_wrap_pulse <= 1'b0;
         r_overflow   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_wrap_pulse <= w_wrap;
         if (w_lo_load) r_lo_q <= w_s_cur;
         if (clr) begin
            r_hi_q     <= '0;
            r_overflow <= 1'b0;
            r_rco_seen <= 1'b0;
         end else begin
            if (w_wrap) r_hi_q <= r_hi_q + 1'b1;
            if (w_wrap && (&r_hi_q)) r_overflow <= 1'b1;
            if (w_rco_s)        r_rco_seen <= 1'b1;
            else if (w_lo_load) r_rco_seen <= 1'b0;
         end
      end
   end

   assign value       = {r_hi_q, r_lo_q};
   assign value_valid = (r_state == RUN);
   assign wrap_pulse  = r_wrap_pulse;
   assign overflow    = r_overflow;

endmodule
